// File: rtl/ddr_wr_rsp.sv
// ddr_wr_rsp
//   AXI4 write-channel responder standing in for one DDR port. Accepts a
//   single write burst at a time, stores strobed 512-bit beats in an internal
//   RAM and answers with BID/BRESP. Burst, error and beat counters are exposed
//   on the CPU register bus.
//
// Ports
//   clk_sys, rst_n              clock, asynchronous active-low reset
//   axi4_m2s_aw* / axi4_s2m_awready   write address channel (awuser ignored)
//   axi4_m2s_w*  / axi4_s2m_wready    write data channel
//   axi4_s2m_b*  / axi4_m2s_bready    write response channel
//   ram_rd_addr / ram_rd_data   back-door RAM read, 1-cycle registered latency
//   cnt_reg_clr                 synchronous clear of all counters
//   cpu_addr, cpu_rd / cpu_data_out   register read port, 1-cycle latency
module ddr_wr_rsp #(
  parameter int                 A_WTH  = 24,
  parameter int                 D_WTH  = 32,
  parameter int                 RAM_AW = 10,
  parameter logic [A_WTH-13:0]  REG_ID = 12'd3
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic [3:0]          axi4_m2s_awid,
  input  logic [63:0]         axi4_m2s_awaddr,
  input  logic [7:0]          axi4_m2s_awlen,
  input  logic [2:0]          axi4_m2s_awsize,
  input  logic [7:0]          axi4_m2s_awuser,
  input  logic                axi4_m2s_awvalid,
  output logic                axi4_s2m_awready,
  input  logic [3:0]          axi4_m2s_wid,
  input  logic [511:0]        axi4_m2s_wdata,
  input  logic [63:0]         axi4_m2s_wstrb,
  input  logic                axi4_m2s_wlast,
  input  logic                axi4_m2s_wvalid,
  output logic                axi4_s2m_wready,
  output logic [3:0]          axi4_s2m_bid,
  output logic [1:0]          axi4_s2m_bresp,
  output logic                axi4_s2m_bvalid,
  input  logic                axi4_m2s_bready,
  input  logic [RAM_AW-1:0]   ram_rd_addr,
  output logic [511:0]        ram_rd_data,
  input  logic                cnt_reg_clr,
  input  logic [A_WTH-1:0]    cpu_addr,
  input  logic                cpu_rd,
  output logic [D_WTH-1:0]    cpu_data_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t              state;
  logic [3:0]          id_q;
  logic [7:0]          len_q;
  logic [RAM_AW-1:0]   waddr;
  logic [8:0]          beat;
  logic                err_sz;
  logic                err_rng;
  logic                err_len;
  logic                err_id;
  logic [31:0]         ok_cnt;
  logic [31:0]         err_cnt;
  logic [31:0]         beat_cnt;
  logic [511:0]        mem [2**RAM_AW];

  logic aw_fire;
  logic w_fire;
  logic b_fire;
  logic beat_len_err;
  logic beat_id_err;
  logic addr_ok;
  logic unused_awuser;

  assign aw_fire = axi4_m2s_awvalid & axi4_s2m_awready;
  assign w_fire  = axi4_m2s_wvalid & axi4_s2m_wready;
  assign b_fire  = axi4_s2m_bvalid & axi4_m2s_bready;
  assign addr_ok = ~(err_sz | err_rng);

  // A burst is too short when wlast comes early and too long once the beat
  // index passes awlen without wlast.
  assign beat_len_err = axi4_m2s_wlast ? (beat != {1'b0, len_q})
                                       : (beat >  {1'b0, len_q});
  assign beat_id_err  = (axi4_m2s_wid != id_q);
  assign unused_awuser = ^axi4_m2s_awuser;

  // ---- burst FSM: address accept, beat tracking, response ----
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      axi4_s2m_awready <= 1'b1;
      axi4_s2m_wready  <= 1'b0;
      axi4_s2m_bvalid  <= 1'b0;
      axi4_s2m_bid     <= 4'd0;
      axi4_s2m_bresp   <= RESP_OKAY;
      beat             <= 9'd0;
      err_sz           <= 1'b0;
      err_rng          <= 1'b0;
      err_len          <= 1'b0;
      err_id           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (aw_fire) begin
            beat             <= 9'd0;
            err_sz           <= (axi4_m2s_awsize != 3'd6);
            err_rng          <= (axi4_m2s_awaddr[63:RAM_AW+6] != '0) ||
                                (axi4_m2s_awaddr[5:0] != 6'd0);
            err_len          <= 1'b0;
            err_id           <= 1'b0;
            axi4_s2m_awready <= 1'b0;
            axi4_s2m_wready  <= 1'b1;
            state            <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_fire) begin
            beat <= beat + 9'd1;
            if (beat_len_err) err_len <= 1'b1;
            if (beat_id_err)  err_id  <= 1'b1;
            if (axi4_m2s_wlast) begin
              axi4_s2m_wready <= 1'b0;
              axi4_s2m_bvalid <= 1'b1;
              axi4_s2m_bid    <= id_q;
              // include this beat's own flags, not yet visible in err_*
              axi4_s2m_bresp  <= (err_sz | err_rng | err_len | err_id |
                                  beat_len_err | beat_id_err) ? RESP_SLVERR
                                                              : RESP_OKAY;
              state           <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (axi4_m2s_bready) begin
            axi4_s2m_bvalid  <= 1'b0;
            axi4_s2m_awready <= 1'b1;
            state            <= S_IDLE;
          end
        end
        default: begin
          axi4_s2m_awready <= 1'b1;
          axi4_s2m_wready  <= 1'b0;
          axi4_s2m_bvalid  <= 1'b0;
          state            <= S_IDLE;
        end
      endcase
    end
  end

  // Burst context; only meaningful between an AW handshake and its response.
  always_ff @(posedge clk_sys) begin
    if (aw_fire) begin
      id_q  <= axi4_m2s_awid;
      len_q <= axi4_m2s_awlen;
      waddr <= axi4_m2s_awaddr[RAM_AW+5:6];
    end else if (w_fire) begin
      waddr <= waddr + 1'b1;
    end
  end

  // ---- RAM write on the beat handshake edge ----
  always_ff @(posedge clk_sys) begin
    if (w_fire && addr_ok) begin
      for (int b = 0; b < 64; b++) begin
        if (axi4_m2s_wstrb[b]) mem[waddr][b*8 +: 8] <= axi4_m2s_wdata[b*8 +: 8];
      end
    end
  end

  // ---- back-door read stage (old data on same-address write) ----
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) ram_rd_data <= '0;
    else        ram_rd_data <= mem[ram_rd_addr];
  end

  // ---- counters; clear wins over a simultaneous increment ----
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt   <= 32'd0;
      err_cnt  <= 32'd0;
      beat_cnt <= 32'd0;
    end else if (cnt_reg_clr) begin
      ok_cnt   <= 32'd0;
      err_cnt  <= 32'd0;
      beat_cnt <= 32'd0;
    end else begin
      if (b_fire && axi4_s2m_bresp == RESP_OKAY)   ok_cnt  <= sat_inc(ok_cnt);
      if (b_fire && axi4_s2m_bresp == RESP_SLVERR) err_cnt <= sat_inc(err_cnt);
      if (w_fire) beat_cnt <= sat_inc(beat_cnt);
    end
  end

  // ---- CPU register read stage ----
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cpu_data_out <= '0;
    end else if (cpu_rd && cpu_addr[A_WTH-1:12] == REG_ID) begin
      case (cpu_addr[11:0])
        12'h000: cpu_data_out <= D_WTH'(ok_cnt);
        12'h004: cpu_data_out <= D_WTH'(err_cnt);
        12'h008: cpu_data_out <= D_WTH'(beat_cnt);
        12'h00C: cpu_data_out <= D_WTH'({30'd0, state});
        default: cpu_data_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_wr_rsp.sv
module tb_ddr_wr_rsp;
  localparam int A_WTH  = 24;
  localparam int D_WTH  = 32;
  localparam int RAM_AW = 10;
  localparam int DEPTH  = 1 << RAM_AW;

  logic               clk_sys;
  logic               rst_n;
  logic [3:0]         awid;
  logic [63:0]        awaddr;
  logic [7:0]         awlen;
  logic [2:0]         awsize;
  logic [7:0]         awuser;
  logic               awvalid;
  logic               awready;
  logic [3:0]         wid;
  logic [511:0]       wdata;
  logic [63:0]        wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;
  logic [3:0]         bid;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;
  logic [RAM_AW-1:0]  ram_rd_addr;
  logic [511:0]       ram_rd_data;
  logic               cnt_reg_clr;
  logic [A_WTH-1:0]   cpu_addr;
  logic               cpu_rd;
  logic [D_WTH-1:0]   cpu_data_out;

  ddr_wr_rsp #(.A_WTH(A_WTH), .D_WTH(D_WTH), .RAM_AW(RAM_AW), .REG_ID(12'd3)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .axi4_m2s_awid(awid), .axi4_m2s_awaddr(awaddr), .axi4_m2s_awlen(awlen),
    .axi4_m2s_awsize(awsize), .axi4_m2s_awuser(awuser),
    .axi4_m2s_awvalid(awvalid), .axi4_s2m_awready(awready),
    .axi4_m2s_wid(wid), .axi4_m2s_wdata(wdata), .axi4_m2s_wstrb(wstrb),
    .axi4_m2s_wlast(wlast), .axi4_m2s_wvalid(wvalid), .axi4_s2m_wready(wready),
    .axi4_s2m_bid(bid), .axi4_s2m_bresp(bresp), .axi4_s2m_bvalid(bvalid),
    .axi4_m2s_bready(bready),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .cnt_reg_clr(cnt_reg_clr),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_data_out(cpu_data_out)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // reference model: RAM bytes known to the bench, plus counters
  logic [511:0] mdl [DEPTH];
  logic [63:0]  mbv [DEPTH];
  int ok_m, err_m, beat_m;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    int          nbeats;
    int          bad_beat;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk512(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] byte_mask(input logic [63:0] m);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  task automatic cpu_read(input logic [11:0] off, output logic [31:0] d);
    @(negedge clk_sys);
    cpu_addr = {12'd3, off};
    cpu_rd   = 1'b1;
    @(negedge clk_sys);
    cpu_rd   = 1'b0;
    d        = cpu_data_out;
  endtask

  task automatic ram_read(input int a, output logic [511:0] d);
    @(negedge clk_sys);
    ram_rd_addr = RAM_AW'(a);
    @(negedge clk_sys);
    d = ram_rd_data;
  endtask

  task automatic chk_counters(input string tag);
    logic [31:0] d;
    cpu_read(12'h000, d); chk({tag, "_ok_cnt"},   d, ok_m);
    cpu_read(12'h004, d); chk({tag, "_err_cnt"},  d, err_m);
    cpu_read(12'h008, d); chk({tag, "_beat_cnt"}, d, beat_m);
  endtask

  task automatic chk_word(input string tag, input int a);
    logic [511:0] d;
    logic [511:0] m;
    ram_read(a, d);
    m = byte_mask(mbv[a]);
    chk512(tag, d & m, mdl[a] & m);
  endtask

  // One complete write transaction. strb_mode: 0 full, 1 random, 2 low 8 bytes.
  task automatic burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input int nbeats, input int bad_beat,
                       input int strb_mode, input int bhold, input bit clr_on_b,
                       output logic [3:0] bid_o, output logic [1:0] bresp_o,
                       output logic [1:0] exp_o);
    int n;
    int viol;
    bit addr_err;
    bit len_err;
    bit id_err;
    logic [RAM_AW-1:0] wa;
    logic [511:0] d;
    logic [63:0] s;
    addr_err = (size != 3'd6) || (addr[63:RAM_AW+6] != '0) || (addr[5:0] != 6'd0);
    len_err  = (nbeats != int'(len) + 1);
    id_err   = (bad_beat >= 0) && (bad_beat < nbeats);
    exp_o    = (addr_err || len_err || id_err) ? 2'b10 : 2'b00;
    wa       = addr[RAM_AW+5:6];
    bid_o    = 4'hx;
    bresp_o  = 2'bxx;

    @(negedge clk_sys);
    awid = id; awaddr = addr; awlen = len; awsize = size; awuser = 8'($urandom); awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(negedge clk_sys); n++; end
    if (!awready) begin chk("aw_timeout", 64'd1, 64'd0); awvalid = 1'b0; return; end
    @(negedge clk_sys);
    awvalid = 1'b0;

    for (int i = 0; i < nbeats; i++) begin
      d = rnd512();
      s = (strb_mode == 0) ? '1 : (strb_mode == 2) ? 64'hFF : {$urandom, $urandom};
      wdata = d; wstrb = s; wlast = (i == nbeats - 1);
      wid = (i == bad_beat) ? ~id : id;
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin @(negedge clk_sys); n++; end
      if (!wready) begin chk("w_timeout", 64'd1, 64'd0); wvalid = 1'b0; return; end
      if (!addr_err) begin
        for (int b = 0; b < 64; b++) begin
          if (s[b]) begin
            mdl[wa][b*8 +: 8] = d[b*8 +: 8];
            mbv[wa][b] = 1'b1;
          end
        end
      end
      wa = wa + 1'b1;
      beat_m++;
      @(negedge clk_sys);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;

    n = 0;
    while (!bvalid && n < 100) begin @(negedge clk_sys); n++; end
    if (!bvalid) begin chk("b_timeout", 64'd1, 64'd0); return; end
    viol = 0;
    for (int h = 0; h < bhold; h++) begin
      if (!bvalid || awready) viol++;
      @(negedge clk_sys);
    end
    if (bhold > 0) chk("b_hold_viol", viol, 0);
    bid_o   = bid;
    bresp_o = bresp;
    bready  = 1'b1;
    cnt_reg_clr = clr_on_b;
    @(negedge clk_sys);
    bready  = 1'b0;
    cnt_reg_clr = 1'b0;
    chk("b_done_bvalid_awready", {bvalid, awready}, 2'b01);
    if (exp_o == 2'b00) ok_m++; else err_m++;
    if (clr_on_b) begin ok_m = 0; err_m = 0; beat_m = 0; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0]  b_id;
    logic [1:0]  b_rs;
    logic [1:0]  b_ex;
    logic [31:0] d32;
    int viol;

    tbl[0] = '{4'd5, 64'h40,           8'd3, 3'd6, 4, -1, 2'b00};
    tbl[1] = '{4'd2, 64'h400,          8'd1, 3'd6, 1, -1, 2'b10};
    tbl[2] = '{4'd3, 64'h800,          8'd0, 3'd6, 1,  0, 2'b10};
    tbl[3] = '{4'd7, 64'h40,           8'd0, 3'd5, 1, -1, 2'b10};
    tbl[4] = '{4'd1, 64'h41,           8'd0, 3'd6, 1, -1, 2'b10};
    tbl[5] = '{4'd9, 64'h1_0000_0040,  8'd0, 3'd6, 1, -1, 2'b10};
    tbl[6] = '{4'd4, 64'h2000,         8'd1, 3'd6, 3, -1, 2'b10};
    tbl[7] = '{4'd6, 64'h3000,         8'd2, 3'd6, 3, -1, 2'b00};

    for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; mbv[i] = '0; end
    ok_m = 0; err_m = 0; beat_m = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awuser = 0; awvalid = 0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    ram_rd_addr = 0; cnt_reg_clr = 0; cpu_addr = 0; cpu_rd = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_sys);

    chk("rst_awready", awready, 1);
    chk("rst_wready",  wready,  0);
    chk("rst_bvalid",  bvalid,  0);
    chk("rst_bid",     bid,     0);
    chk("rst_bresp",   bresp,   0);
    chk("rst_cpu_data_out", cpu_data_out, 0);
    chk512("rst_ram_rd_data", ram_rd_data, '0);
    rst_n = 1'b1;
    chk_counters("rst");
    cpu_read(12'h00C, d32); chk("rst_state", d32, 0);

    // table-driven bursts
    for (int i = 0; i < 8; i++) begin
      burst(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].nbeats,
            tbl[i].bad_beat, 0, 0, 1'b0, b_id, b_rs, b_ex);
      chk($sformatf("tbl%0d_bid", i), b_id, tbl[i].id);
      chk($sformatf("tbl%0d_bresp", i), b_rs, tbl[i].exp_resp);
      if (i == 0) begin
        cpu_read(12'h000, d32); chk("t1_ok_cnt", d32, 1);
        cpu_read(12'h008, d32); chk("t1_beat_cnt", d32, 4);
        for (int w = 1; w <= 4; w++) chk_word($sformatf("t1_ram%0d", w), w);
      end
      if (i == 2) begin
        cpu_read(12'h004, d32); chk("t3_err_cnt", d32, 2);
      end
    end
    chk_counters("tbl");
    chk_word("size_rng_err_nochange", 1);

    // partial strobe over a known word
    burst(4'd8, 64'h80, 8'd0, 3'd6, 1, -1, 2, 0, 1'b0, b_id, b_rs, b_ex);
    chk("strb_bresp", b_rs, 2'b00);
    chk_word("strb_word2", 2);

    // misaligned burst with response held off for 10 cycles
    burst(4'hA, 64'h41, 8'd0, 3'd6, 1, -1, 0, 10, 1'b0, b_id, b_rs, b_ex);
    chk("hold_bid", b_id, 4'hA);
    chk("hold_bresp", b_rs, 2'b10);
    chk_word("hold_word1_nochange", 1);

    // wrap from the top RAM word to word 0
    burst(4'hB, 64'(DEPTH - 1) << 6, 8'd1, 3'd6, 2, -1, 0, 0, 1'b0, b_id, b_rs, b_ex);
    chk("wrap_bresp", b_rs, 2'b00);
    chk_word("wrap_top", DEPTH - 1);
    chk_word("wrap_zero", 0);

    // clear pulsed on the B handshake
    burst(4'hD, 64'h100, 8'd0, 3'd6, 1, -1, 0, 0, 1'b1, b_id, b_rs, b_ex);
    chk("clr_bresp", b_rs, 2'b00);
    chk_counters("clr");

    // reset during beat 2 of an 8-beat burst
    @(negedge clk_sys);
    awid = 4'hC; awaddr = 64'h5000; awlen = 8'd7; awsize = 3'd6; awvalid = 1'b1;
    while (!awready) @(negedge clk_sys);
    @(negedge clk_sys);
    awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wdata = rnd512(); wstrb = '1; wlast = 1'b0; wid = 4'hC; wvalid = 1'b1;
      if (i < 2) begin
        mdl[320 + i] = wdata; mbv[320 + i] = '1;
        @(negedge clk_sys);
      end else begin
        rst_n = 1'b0;
        #1;
        chk("midrst_wready", wready, 0);
        chk("midrst_bvalid", bvalid, 0);
        chk("midrst_awready", awready, 1);
      end
    end
    ok_m = 0; err_m = 0; beat_m = 0;
    @(negedge clk_sys);
    wvalid = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    viol = 0;
    for (int c = 0; c < 8; c++) begin
      if (bvalid) viol++;
      @(negedge clk_sys);
    end
    chk("midrst_no_bvalid", viol, 0);
    cpu_read(12'h00C, d32); chk("midrst_state", d32, 0);
    chk_counters("midrst");
    chk_word("midrst_beat0", 320);
    chk_word("midrst_beat1", 321);
    burst(4'hE, 64'h6000, 8'd1, 3'd6, 2, -1, 0, 0, 1'b0, b_id, b_rs, b_ex);
    chk("post_rst_bid", b_id, 4'hE);
    chk("post_rst_bresp", b_rs, 2'b00);

    // randomized bursts against the model
    for (int t = 0; t < 40; t++) begin
      logic [3:0]  r_id;
      logic [63:0] r_addr;
      logic [7:0]  r_len;
      logic [2:0]  r_size;
      int r_nb, r_bad, sel;
      r_id   = 4'($urandom_range(0, 15));
      r_len  = 8'($urandom_range(0, 5));
      r_size = ($urandom_range(0, 9) == 0) ? 3'd5 : 3'd6;
      r_addr = 64'($urandom_range(0, DEPTH - 1)) << 6;
      sel = $urandom_range(0, 11);
      if (sel == 0) r_addr[5:0] = 6'($urandom_range(1, 63));
      if (sel == 1) r_addr[40] = 1'b1;
      r_nb = int'(r_len) + 1;
      sel = $urandom_range(0, 7);
      if (sel == 0) r_nb = int'(r_len) + 2;
      if (sel == 1 && r_len != 0) r_nb = int'(r_len);
      r_bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, r_nb - 1) : -1;
      burst(r_id, r_addr, r_len, r_size, r_nb, r_bad, $urandom_range(0, 1),
            $urandom_range(0, 3), 1'b0, b_id, b_rs, b_ex);
      chk($sformatf("rnd%0d_bid", t), b_id, r_id);
      chk($sformatf("rnd%0d_bresp", t), b_rs, b_ex);
    end
    chk_counters("rnd");
    for (int w = 0; w < DEPTH; w++) begin
      if (mbv[w] != '0) chk_word($sformatf("sweep_ram%0d", w), w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
